uart_receiver: RTL and testbench

Serial byte receiver fed by the clock prescaler: consumes the raw `rx` pin and the 5x-baud `uart_clk` and delivers framed 8N1 bytes to the command decoder through a valid/ready handshake. Runs entirely on the oscillator clock `clk` and uses `uart_clk` only as a sample-enable source. Reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_receiver.sv | 211 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1-style serial receiver (DATA_BITS data bits, LSB first)
// running on clk, using the 5x-baud uart_clk only as a sample enable.
// Delivers bytes through a valid/ready holding register and pulses
// rx_ferr / rx_overrun for one clk on framing errors and dropped bytes.
// Optional build macro: UART_MAJORITY_EN -- bit value is the 2-of-3 majority
// of the phase 1/2/3 samples; otherwise the phase 2 sample alone is used.
module uart_receiver #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 uart_clk,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 uart_clk_q, uart_clk_d;
  logic                 tick;

  state_e               state_q, state_d;
  logic [2:0]           phase_q, phase_d;
  logic [2:0]           bit_idx_q, bit_idx_d;

  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 samp2_q, samp2_d;
`ifdef UART_MAJORITY_EN
  logic                 samp1_q, samp1_d;
  logic                 samp3_q, samp3_d;
`endif
  logic                 bit_val;
  logic                 framed;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_overrun_q, rx_overrun_d;
  logic                 busy_q, busy_d;

  // Synchronizer / edge-detect next values; tick marks each uart_clk rising edge.
  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    uart_clk_d = uart_clk;
    tick       = uart_clk & ~uart_clk_q;
  end

  // Two-stage rx synchronizer and uart_clk edge-detect register, all reset high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      uart_clk_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      uart_clk_q <= uart_clk_d;
    end
  end

  // Bit decision from the captured phase samples.
  always_comb begin
`ifdef UART_MAJORITY_EN
    bit_val = (samp1_q & samp2_q) | (samp1_q & samp3_q) | (samp2_q & samp3_q);
`else
    bit_val = samp2_q;
`endif
    framed = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  end

  // FSM state register with phase and bit-index counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Next-state logic; every transition is qualified by tick.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d = S_START;
            phase_d = 3'd1;
          end
        end
        S_START, S_DATA, S_STOP: begin
          phase_d = (phase_q == 3'd4) ? '0 : phase_q + 3'd1;
          if (phase_q == 3'd4) begin
            case (state_q)
              S_START: begin
                if (bit_val) begin
                  state_d = S_IDLE;
                end else begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
                end
              end
              S_DATA: begin
                if (bit_idx_q == LAST_IDX) state_d = S_STOP;
                else                       bit_idx_d = bit_idx_q + 3'd1;
              end
              default: state_d = bit_val ? S_IDLE : S_WAIT;
            endcase
          end
        end
        S_WAIT: begin
          if (rx_sync_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath logic: sampling, shifting, delivery and error pulses.
  always_comb begin
    shift_d      = shift_q;
    samp2_d      = samp2_q;
`ifdef UART_MAJORITY_EN
    samp1_d      = samp1_q;
    samp3_d      = samp3_q;
`endif
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;
    rx_ferr_d    = 1'b0;
    rx_overrun_d = 1'b0;
    busy_d       = (state_q != S_IDLE);
    if (tick && framed) begin
      if (phase_q == 3'd2) samp2_d = rx_sync_q;
`ifdef UART_MAJORITY_EN
      if (phase_q == 3'd1) samp1_d = rx_sync_q;
      if (phase_q == 3'd3) samp3_d = rx_sync_q;
`endif
      if (phase_q == 3'd4) begin
        if (state_q == S_DATA) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
        if (state_q == S_STOP) begin
          if (!bit_val) begin
            rx_ferr_d = 1'b1;
          end else if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_overrun_d = 1'b1;
          end
        end
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q      <= '0;
      samp2_q      <= 1'b1;
`ifdef UART_MAJORITY_EN
      samp1_q      <= 1'b1;
      samp3_q      <= 1'b1;
`endif
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      samp2_q      <= samp2_d;
`ifdef UART_MAJORITY_EN
      samp1_q      <= samp1_d;
      samp3_q      <= samp3_d;
`endif
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_overrun_q <= rx_overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_ferr    = rx_ferr_q;
  assign rx_overrun = rx_overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver. uart_clk is shortened to one rising edge
// every 10 clk (bit = 50 clk) so the run stays short; all tick-relative
// timing is unchanged. uart_clk edges land 1 time unit after a clk posedge.
module tb_uart_receiver;
  localparam int DATA_BITS = 8;
  localparam int TICK_CLKS = 10;
  localparam int TICK_T    = 100;  // time units per tick (clk period 10)
  localparam int BIT_T     = 500;  // 5 ticks per bit

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic       uart_clk = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, rx_overrun, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = 0, valid_rise_cyc = 0, busy_fall_cyc = 0, rel_cyc = 0;
  int valid_rises = 0, valid_cycles = 0, ferr_cnt = 0, ovr_cnt = 0, busy_rises = 0;
  int s_vr, s_vc, s_fe, s_ov, s_br;
  logic prev_valid = 1'b0, prev_busy = 1'b0;
  logic [7:0] hs_q[$];
  logic [7:0] glitch_exp;

  uart_receiver #(.DATA_BITS(DATA_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .uart_clk  (uart_clk),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_ferr   (rx_ferr),
    .rx_overrun(rx_overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  initial begin
    #56;
    forever #50 uart_clk = ~uart_clk;
  end

  always @(posedge clk) cyc++;

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) hs_q.push_back(rx_data);
    if (rx_valid) valid_cycles++;
    if (rx_valid && !prev_valid) begin valid_rises++; valid_rise_cyc = cyc; end
    if (rx_ferr) ferr_cnt++;
    if (rx_overrun) ovr_cnt++;
    if (busy && !prev_busy) busy_rises++;
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    prev_valid = rx_valid;
    prev_busy  = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_vr = valid_rises; s_vc = valid_cycles; s_fe = ferr_cnt; s_ov = ovr_cnt; s_br = busy_rises;
  endtask

  // Start bit, LSB-first data, stop bit; optional one-tick inverted glitch
  // centred on the phase-2 sample of data bit glitch_bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int glitch_bit);
    fall_cyc = cyc;
    rx = 1'b0;
    #BIT_T;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == glitch_bit) begin
        #257; rx = ~data[i]; #100; rx = data[i]; #143;
      end else begin
        #BIT_T;
      end
    end
    rx = stop_bit;
    #BIT_T;
  endtask

  task automatic idle(input int ticks);
    rx = 1'b1;
    #(ticks * TICK_T);
  endtask

  initial begin
`ifdef UART_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    repeat (4) @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ferr", rx_ferr, 1'b0);
    check("rst_ovr", rx_overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge uart_clk); #2;
    idle(3);

    // Frame 0xA5; rx_valid edge = 1 tick to the detect-tick cycle + 49 ticks + 1 clk
    snap();
    send_frame(8'hA5, 1'b1, -1);
    idle(2);
    check("t1_valid", rx_valid, 1'b1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_latency", valid_rise_cyc - fall_cyc, TICK_CLKS + 49 * TICK_CLKS + 1);
    check("t1_ferr", ferr_cnt - s_fe, 0);
    check("t1_ovr", ovr_cnt - s_ov, 0);
    rx_ready = 1'b1;
    idle(1);
    check("t1_consumed", rx_valid, 1'b0);
    check("t1_hs_n", hs_q.size(), 1);
    check("t1_hs_data", hs_q[0], 8'hA5);

    // Back-to-back 0x00 / 0xFF with rx_ready high
    hs_q.delete(); snap();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(2);
    check("t2_hs_n", hs_q.size(), 2);
    check("t2_hs0", hs_q[0], 8'h00);
    check("t2_hs1", hs_q[1], 8'hFF);
    check("t2_valid_cycles", valid_cycles - s_vc, 2);
    check("t2_valid_low", rx_valid, 1'b0);

    // Framing error then break held low for 20 bits
    snap();
    send_frame(8'h3C, 1'b0, -1);
    #(20 * BIT_T);
    check("t3_busy_wait", busy, 1'b1);
    check("t3_ferr", ferr_cnt - s_fe, 1);
    rel_cyc = cyc;
    idle(3);
    // tick at edge 1 still sees the old sync value, tick at edge 11 returns to IDLE
    check("t3_busy_fall", busy_fall_cyc - rel_cyc, 12);
    check("t3_no_valid", valid_rises - s_vr, 0);
    check("t3_busy_idle", busy, 1'b0);

    // 1.5-tick low glitch: false start
    snap();
    rx = 1'b0; #150; rx = 1'b1; #850;
    idle(2);
    check("t4_started", busy_rises - s_br, 1);
    check("t4_no_valid", valid_rises - s_vr, 0);
    check("t4_no_ferr", ferr_cnt - s_fe, 0);
    check("t4_no_ovr", ovr_cnt - s_ov, 0);
    check("t4_busy", busy, 1'b0);

    // One-tick high glitch on phase 2 of data bit 3 in frame 0x00
    hs_q.delete();
    send_frame(8'h00, 1'b1, 3);
    idle(2);
    check("t5_hs_n", hs_q.size(), 1);
    check("t5_data", hs_q[0], glitch_exp);

    // Overrun: 0x11 then 0x22 with rx_ready low
    rx_ready = 1'b0; snap();
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(2);
    check("t6_valid", rx_valid, 1'b1);
    check("t6_data_kept", rx_data, 8'h11);
    check("t6_ovr", ovr_cnt - s_ov, 1);
    check("t6_valid_rises", valid_rises - s_vr, 1);
    hs_q.delete();
    rx_ready = 1'b1; #10; rx_ready = 1'b0; #90;
    check("t6_hs", hs_q[0], 8'h11);
    check("t6_drained", rx_valid, 1'b0);

    // Consume on the delivery cycle of 0x22: it loads, no overrun
    hs_q.delete();
    send_frame(8'h11, 1'b1, -1);
    idle(2);
    check("t6b_held", rx_data, 8'h11);
    snap();
    fork
      send_frame(8'h22, 1'b1, -1);
      begin
        #(10 * BIT_T);
        rx_ready = 1'b1; #10; rx_ready = 1'b0;
      end
    join
    idle(2);
    check("t6b_data", rx_data, 8'h22);
    check("t6b_valid", rx_valid, 1'b1);
    check("t6b_no_ovr", ovr_cnt - s_ov, 0);
    check("t6b_hs_n", hs_q.size(), 1);
    check("t6b_hs", hs_q[0], 8'h11);

    // Reset in the middle of a frame
    fork
      send_frame(8'h5A, 1'b1, -1);
      begin
        #2000;
        check("t7_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #12;
        check("t7_data", rx_data, 8'h00);
        check("t7_valid", rx_valid, 1'b0);
        check("t7_ferr", rx_ferr, 1'b0);
        check("t7_ovr", rx_overrun, 1'b0);
        check("t7_busy", busy, 1'b0);
      end
    join
    rst_n = 1'b1;
    idle(3);

    // Recovery after reset
    rx_ready = 1'b1; hs_q.delete();
    send_frame(8'hC3, 1'b1, -1);
    idle(2);
    check("t8_hs_n", hs_q.size(), 1);
    check("t8_data", hs_q[0], 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
